// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared dimensions and pixel/row types for the LED matrix frame buffer
package matrix_pkg;
    localparam int MATRIX_WIDTH    = 64;
    localparam int MATRIX_HEIGHT   = 32;
    localparam int ADDR_WIDTH      = 8;
    localparam int DATA_WIDTH      = 8;
    localparam int ROW_LENGTH      = 7;
    localparam int COLUMN_LENGTH   = 6;
    localparam int INTERFACE_WIDTH = 3 * DATA_WIDTH;
    localparam int SCAN_VAL_LENGTH = 5;

    localparam int HALF_HEIGHT = MATRIX_HEIGHT / 2;
    localparam int ROW_IDX_W   = $clog2(MATRIX_HEIGHT);
    localparam int COL_IDX_W   = $clog2(MATRIX_WIDTH);
    localparam int BIT_IDX_W   = $clog2(DATA_WIDTH);
    localparam int PIX_IDX_W   = $clog2(INTERFACE_WIDTH);

    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] g;
        logic [DATA_WIDTH-1:0] b;
    } pixel_t;

    typedef pixel_t [MATRIX_WIDTH-1:0] row_t;
endpackage

// File: rtl/matrix_bitplane_select.sv
// rtl/matrix_bitplane_select.sv - extracts one R/G/B bit-plane of a pixel row as column masks
module matrix_bitplane_select
    import matrix_pkg::*;
(
    input  row_t                    i_row,
    input  logic [BIT_IDX_W-1:0]    i_bit,
    input  logic                    i_valid,
    output logic [MATRIX_WIDTH-1:0] o_r,
    output logic [MATRIX_WIDTH-1:0] o_g,
    output logic [MATRIX_WIDTH-1:0] o_b
);
    logic [PIX_IDX_W-1:0] w_r_idx;
    logic [PIX_IDX_W-1:0] w_g_idx;
    logic [PIX_IDX_W-1:0] w_b_idx;

    assign w_r_idx = PIX_IDX_W'(R_OFS) + PIX_IDX_W'(i_bit);
    assign w_g_idx = PIX_IDX_W'(G_OFS) + PIX_IDX_W'(i_bit);
    assign w_b_idx = PIX_IDX_W'(B_OFS) + PIX_IDX_W'(i_bit);

    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            o_r[i] = i_valid & i_row[i][w_r_idx];
            o_g[i] = i_valid & i_row[i][w_g_idx];
            o_b[i] = i_valid & i_row[i][w_b_idx];
        end
    end
endmodule

// File: rtl/led_matrix_memory.sv
// rtl/led_matrix_memory.sv - flop-based RGB frame buffer with processor port and dual-row bit-plane scan port
module led_matrix_memory
    import matrix_pkg::*;
(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [ROW_LENGTH-1:0]      proc_ctrl_row,
    input  logic [COLUMN_LENGTH-1:0]   proc_ctrl_col,
    input  logic                       proc_ctrl_we,
    input  logic [INTERFACE_WIDTH-1:0] proc_ctrl_data_i,
    output logic [INTERFACE_WIDTH-1:0] proc_ctrl_data_o,
    input  logic [SCAN_VAL_LENGTH-1:0] scan_val,
    input  logic [DATA_WIDTH-1:0]      current_bcm_bit,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_ra,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_ga,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_ba,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_rb,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_gb,
    output logic [MATRIX_WIDTH-1:0]    pwm_data_bb
);
    row_t r_pixels [MATRIX_HEIGHT];

    logic                    w_proc_ok;
    logic [ROW_IDX_W-1:0]    w_row_idx;
    logic [COL_IDX_W-1:0]    w_col_idx;
    logic                    w_plane_ok;
    logic [ROW_IDX_W-1:0]    w_scan_a;
    logic [ROW_IDX_W-1:0]    w_scan_b;
    logic [BIT_IDX_W-1:0]    w_bit;
    logic [MATRIX_WIDTH-1:0] w_ra, w_ga, w_ba, w_rb, w_gb, w_bb;

    // Range checks use the full input width so out-of-range addresses never alias onto real pixels.
    assign w_proc_ok  = (32'(proc_ctrl_row) < MATRIX_HEIGHT) && (32'(proc_ctrl_col) < MATRIX_WIDTH);
    assign w_row_idx  = proc_ctrl_row[ROW_IDX_W-1:0];
    assign w_col_idx  = proc_ctrl_col[COL_IDX_W-1:0];
    assign w_plane_ok = (32'(scan_val) < HALF_HEIGHT) && (32'(current_bcm_bit) < DATA_WIDTH);
    assign w_scan_a   = scan_val[ROW_IDX_W-1:0];
    assign w_scan_b   = w_scan_a + ROW_IDX_W'(HALF_HEIGHT);
    assign w_bit      = current_bcm_bit[BIT_IDX_W-1:0];

    matrix_bitplane_select u_sel_a (
        .i_row   (r_pixels[w_scan_a]),
        .i_bit   (w_bit),
        .i_valid (w_plane_ok),
        .o_r     (w_ra),
        .o_g     (w_ga),
        .o_b     (w_ba)
    );

    matrix_bitplane_select u_sel_b (
        .i_row   (r_pixels[w_scan_b]),
        .i_bit   (w_bit),
        .i_valid (w_plane_ok),
        .o_r     (w_rb),
        .o_g     (w_gb),
        .o_b     (w_bb)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
                r_pixels[r] <= '0;
            end
            proc_ctrl_data_o <= '0;
            pwm_data_ra      <= '0;
            pwm_data_ga      <= '0;
            pwm_data_ba      <= '0;
            pwm_data_rb      <= '0;
            pwm_data_gb      <= '0;
            pwm_data_bb      <= '0;
        end else begin
            if (proc_ctrl_we && w_proc_ok) begin
                r_pixels[w_row_idx][w_col_idx] <= proc_ctrl_data_i;
            end
            // Reads sample the pre-edge array, so same-edge writes become visible one cycle later.
            proc_ctrl_data_o <= w_proc_ok ? r_pixels[w_row_idx][w_col_idx] : '0;
            pwm_data_ra      <= w_ra;
            pwm_data_ga      <= w_ga;
            pwm_data_ba      <= w_ba;
            pwm_data_rb      <= w_rb;
            pwm_data_gb      <= w_gb;
            pwm_data_bb      <= w_bb;
        end
    end
endmodule

// File: tb/tb_led_matrix_memory.sv
// tb/tb_led_matrix_memory.sv - self-checking bench: directed vector table plus randomized model comparison
module tb_led_matrix_memory;
    logic        clk = 1'b0;
    logic        n_rst;
    logic [6:0]  proc_ctrl_row;
    logic [5:0]  proc_ctrl_col;
    logic        proc_ctrl_we;
    logic [23:0] proc_ctrl_data_i;
    logic [23:0] proc_ctrl_data_o;
    logic [4:0]  scan_val;
    logic [7:0]  current_bcm_bit;
    logic [63:0] pwm_data_ra, pwm_data_ga, pwm_data_ba;
    logic [63:0] pwm_data_rb, pwm_data_gb, pwm_data_bb;

    always #5 clk = ~clk;

    led_matrix_memory dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .proc_ctrl_row    (proc_ctrl_row),
        .proc_ctrl_col    (proc_ctrl_col),
        .proc_ctrl_we     (proc_ctrl_we),
        .proc_ctrl_data_i (proc_ctrl_data_i),
        .proc_ctrl_data_o (proc_ctrl_data_o),
        .scan_val         (scan_val),
        .current_bcm_bit  (current_bcm_bit),
        .pwm_data_ra      (pwm_data_ra),
        .pwm_data_ga      (pwm_data_ga),
        .pwm_data_ba      (pwm_data_ba),
        .pwm_data_rb      (pwm_data_rb),
        .pwm_data_gb      (pwm_data_gb),
        .pwm_data_bb      (pwm_data_bb)
    );

    typedef struct {
        int          row;
        int          col;
        bit          we;
        logic [23:0] data;
        int          sv;
        int          b;
        logic [23:0] e_d;
        logic [63:0] e_ra, e_ga, e_ba, e_rb, e_gb, e_bb;
    } vec_t;

    localparam logic [63:0] Z    = 64'h0;
    localparam logic [63:0] C2   = 64'h4;
    localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = {64{1'b1}};

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] mem [32][64];
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] m_read(int r, int c);
        if (r < 32 && c < 64) return mem[r][c];
        return 24'h0;
    endfunction

    // Bit-plane of the scan row (half 0 = row A, half 1 = row B) for one channel offset.
    function automatic logic [63:0] m_plane(int sv, int b, int half, int ofs);
        logic [63:0] m = '0;
        if (sv >= 16 || b >= 8) return m;
        for (int i = 0; i < 64; i++)
            m[i] = ((mem[sv + 16 * half][i] >> (ofs + b)) & 24'h1) != 0;
        return m;
    endfunction

    function automatic vec_t mk(int row, int col, bit we, logic [23:0] data, int sv, int b,
                                logic [23:0] e_d, logic [63:0] ra, logic [63:0] ga, logic [63:0] ba,
                                logic [63:0] rb, logic [63:0] gb, logic [63:0] bb);
        vec_t v;
        v.row = row; v.col = col; v.we = we; v.data = data; v.sv = sv; v.b = b;
        v.e_d = e_d; v.e_ra = ra; v.e_ga = ga; v.e_ba = ba; v.e_rb = rb; v.e_gb = gb; v.e_bb = bb;
        return v;
    endfunction

    task automatic check_all(input string tag, input vec_t v);
        chk($sformatf("%s data_o", tag), {40'h0, proc_ctrl_data_o}, {40'h0, v.e_d});
        chk($sformatf("%s ra", tag), pwm_data_ra, v.e_ra);
        chk($sformatf("%s ga", tag), pwm_data_ga, v.e_ga);
        chk($sformatf("%s ba", tag), pwm_data_ba, v.e_ba);
        chk($sformatf("%s rb", tag), pwm_data_rb, v.e_rb);
        chk($sformatf("%s gb", tag), pwm_data_gb, v.e_gb);
        chk($sformatf("%s bb", tag), pwm_data_bb, v.e_bb);
    endtask

    // One clock: drive at negedge, compare #1 after posedge; model or table supplies expectations.
    task automatic run(input string tag, input vec_t v, input bit use_model, input bit do_check);
        vec_t e;
        @(negedge clk);
        proc_ctrl_row    = 7'(v.row);
        proc_ctrl_col    = 6'(v.col);
        proc_ctrl_we     = v.we;
        proc_ctrl_data_i = v.data;
        scan_val         = 5'(v.sv);
        current_bcm_bit  = 8'(v.b);
        e = v;
        if (use_model) begin
            e.e_d  = m_read(v.row, v.col);
            e.e_ra = m_plane(v.sv, v.b, 0, 16);
            e.e_ga = m_plane(v.sv, v.b, 0, 8);
            e.e_ba = m_plane(v.sv, v.b, 0, 0);
            e.e_rb = m_plane(v.sv, v.b, 1, 16);
            e.e_gb = m_plane(v.sv, v.b, 1, 8);
            e.e_bb = m_plane(v.sv, v.b, 1, 0);
        end
        @(posedge clk);
        #1;
        if (do_check) check_all(tag, e);
        if (v.we && v.row < 32 && v.col < 64) mem[v.row][v.col] = v.data;
    endtask

    initial begin
        n_rst = 1'b0;
        proc_ctrl_row = '0; proc_ctrl_col = '0; proc_ctrl_we = 1'b0;
        proc_ctrl_data_i = '0; scan_val = '0; current_bcm_bit = '0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", mk(0, 0, 0, 0, 0, 0, 24'h0, Z, Z, Z, Z, Z, Z));
        @(negedge clk);
        n_rst = 1'b1;

        tbl.push_back(mk(5, 2, 1, 24'h010204, 5, 0, 24'h0,      Z,  Z,  Z,  Z,   Z,   Z));
        tbl.push_back(mk(5, 2, 0, 24'h0,      5, 0, 24'h010204, C2, Z,  Z,  Z,   Z,   Z));
        tbl.push_back(mk(5, 2, 0, 24'h0,      5, 1, 24'h010204, Z,  C2, Z,  Z,   Z,   Z));
        tbl.push_back(mk(5, 2, 0, 24'h0,      5, 2, 24'h010204, Z,  Z,  C2, Z,   Z,   Z));
        for (int b = 3; b < 8; b++)
            tbl.push_back(mk(5, 2, 0, 24'h0,  5, b, 24'h010204, Z,  Z,  Z,  Z,   Z,   Z));
        tbl.push_back(mk(21, 63, 1, 24'hFFFFFF, 5, 7, 24'h0,      Z, Z, Z, Z,   Z,   Z));
        tbl.push_back(mk(21, 63, 0, 24'h0,      5, 7, 24'hFFFFFF, Z, Z, Z, TOP, TOP, TOP));
        tbl.push_back(mk(31, 0, 1, 24'hA5C3F0,  5, 7, 24'h0,      Z, Z, Z, TOP, TOP, TOP));
        tbl.push_back(mk(31, 0, 0, 24'h0,       5, 7, 24'hA5C3F0, Z, Z, Z, TOP, TOP, TOP));
        tbl.push_back(mk(31, 0, 1, 24'h123456,  5, 7, 24'hA5C3F0, Z, Z, Z, TOP, TOP, TOP));
        tbl.push_back(mk(31, 0, 0, 24'h0,       5, 7, 24'h123456, Z, Z, Z, TOP, TOP, TOP));
        tbl.push_back(mk(40, 2, 1, 24'hFFFFFF, 21, 0, 24'h0,      Z, Z, Z, Z,   Z,   Z));
        tbl.push_back(mk(8, 2, 0, 24'h0,        5, 8, 24'h0,      Z, Z, Z, Z,   Z,   Z));
        tbl.push_back(mk(5, 2, 0, 24'h0,       16, 0, 24'h010204, Z, Z, Z, Z,   Z,   Z));
        foreach (tbl[k]) run($sformatf("vec%0d", k), tbl[k], 1'b0, 1'b1);

        for (int c = 0; c < 64; c++)
            run("rowfill", mk(0, c, 1, 24'h808080, 0, 0, 0, Z, Z, Z, Z, Z, Z), 1'b1, 1'b1);
        run("row0 b7", mk(0, 0, 0, 0, 0, 7, 24'h808080, ONES, ONES, ONES, Z, Z, Z), 1'b0, 1'b1);
        run("row0 b6", mk(0, 0, 0, 0, 0, 6, 24'h808080, Z, Z, Z, Z, Z, Z), 1'b0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk($urandom_range(0, 39), $urandom_range(0, 63), $urandom_range(0, 1) == 1,
                   24'($urandom), $urandom_range(0, 18), $urandom_range(0, 9),
                   0, Z, Z, Z, Z, Z, Z);
            if (n % 4 == 0) v.row = 32'(v.sv) + 16 * $urandom_range(0, 1);
            run($sformatf("rand%0d", n), v, 1'b1, 1'b1);
        end

        run("pre-rst", mk(0, 5, 0, 0, 0, 7, 0, Z, Z, Z, Z, Z, Z), 1'b1, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check_all("midrst", mk(0, 0, 0, 0, 0, 0, 24'h0, Z, Z, Z, Z, Z, Z));
        @(negedge clk);
        n_rst = 1'b1;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 24'h0;
        run("post-rst a", mk(31, 0, 0, 0, 0, 7, 24'h0, Z, Z, Z, Z, Z, Z), 1'b0, 1'b1);
        run("post-rst b", mk(5, 2, 0, 0, 5, 0, 24'h0, Z, Z, Z, Z, Z, Z), 1'b0, 1'b1);
        run("post-rst c", mk(21, 63, 0, 0, 5, 7, 24'h0, Z, Z, Z, Z, Z, Z), 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
